nexus_bucket_pifo: RTL and testbench



---
 rtl/nexus_bucket_pifo_pkg.sv | 29 ++
 rtl/nexus_bucket_pifo_if.sv | 35 +++
 rtl/nexus_bucket_pifo_ffs.sv | 23 ++
 rtl/nexus_bucket_pifo.sv | 141 ++++++++++++++
 tb/tb_nexus_bucket_pifo.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nexus_bucket_pifo_pkg.sv
// Shared types and default geometry for the bucket-approximate PIFO.
// Index widths never collapse to zero so single-tenant/single-bucket builds stay legal.
package nexus_pifo_pkg;

    localparam int unsigned PTW_DEF     = 16;
    localparam int unsigned MTW_DEF     = 32;
    localparam int unsigned NB_DEF      = 16;
    localparam int unsigned DEPTH_DEF   = 64;
    localparam int unsigned TENANTS_DEF = 4;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned BKW = idx_w(NB_DEF);
    localparam int unsigned ADW = $clog2(DEPTH_DEF);
    localparam int unsigned TNW = idx_w(TENANTS_DEF);

    typedef logic [BKW-1:0] bkt_idx_t;
    typedef logic [ADW-1:0] ptr_t;
    typedef logic [TNW-1:0] tenant_t;

    typedef struct packed {
        logic [PTW_DEF-1:0] prio;
        tenant_t            tenant;
        logic [MTW_DEF-1:0] meta;
    } entry_t;

endpackage

// File: rtl/nexus_bucket_pifo_if.sv
// Push/pop/status bundle of the bucket PIFO; master drives requests, slave is the queue.
interface nexus_bucket_pifo_if #(
    parameter int unsigned PTW = 16,
    parameter int unsigned MTW = 32,
    parameter int unsigned TNW = 2,
    parameter int unsigned ADW = 6
);
    logic           i_push_valid;
    logic           o_push_ready;
    logic [PTW-1:0] i_push_prio;
    logic [TNW-1:0] i_push_tenant;
    logic [MTW-1:0] i_push_meta;
    logic           i_pop;
    logic           o_pop_valid;
    logic [PTW-1:0] o_pop_prio;
    logic [TNW-1:0] o_pop_tenant;
    logic [MTW-1:0] o_pop_meta;
    logic           o_drop;
    logic [TNW-1:0] o_drop_tenant;
    logic [ADW:0]   o_count;
    logic           o_empty;
    logic           o_full;

    modport master (
        output i_push_valid, i_push_prio, i_push_tenant, i_push_meta, i_pop,
        input  o_push_ready, o_pop_valid, o_pop_prio, o_pop_tenant, o_pop_meta,
        input  o_drop, o_drop_tenant, o_count, o_empty, o_full
    );

    modport slave (
        input  i_push_valid, i_push_prio, i_push_tenant, i_push_meta, i_pop,
        output o_push_ready, o_pop_valid, o_pop_prio, o_pop_tenant, o_pop_meta,
        output o_drop, o_drop_tenant, o_count, o_empty, o_full
    );
endinterface

// File: rtl/nexus_bucket_pifo_ffs.sv
// Lowest-set-bit finder over the bucket occupancy bitmap.
module nexus_bucket_ffs
    import nexus_pifo_pkg::*;
#(
    parameter int unsigned NB = 16,
    parameter int unsigned IW = idx_w(NB)
) (
    input  logic [NB-1:0] i_bitmap,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        o_idx = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (i_bitmap[i]) o_idx = IW'(i);
        end
    end

    assign o_any = |i_bitmap;

endmodule

// File: rtl/nexus_bucket_pifo.sv
// Multi-tenant bucket-approximate PIFO: per-bucket FIFO linked lists in a shared pool,
// free-list recycling, lowest-bucket-first pop and per-tenant quotas with drop reporting.
module nexus_bucket_pifo
    import nexus_pifo_pkg::*;
#(
    parameter int unsigned PTW     = 16,
    parameter int unsigned MTW     = 32,
    parameter int unsigned NB      = 16,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned TENANTS = 4,
    parameter int unsigned QUOTA   = 32
) (
    input logic                i_clk,
    input logic                i_rst,
    nexus_bucket_pifo_if.slave io_bus
);

    localparam int unsigned BW = idx_w(NB);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = idx_w(TENANTS);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] QUOTA_CNT = CW'(QUOTA);

    typedef struct packed {
        logic [PTW-1:0] prio;
        logic [TW-1:0]  tenant;
        logic [MTW-1:0] meta;
    } slot_t;

    slot_t         r_mem  [DEPTH];
    logic [AW-1:0] r_next [DEPTH];
    logic [AW-1:0] r_head [NB];
    logic [AW-1:0] r_tail [NB];
    logic [CW-1:0] r_tcnt [TENANTS];
    logic [NB-1:0] r_bitmap;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_free;
    logic          r_pop_valid;
    slot_t         r_pop;
    logic          r_drop;
    logic [TW-1:0] r_drop_tenant;

    logic          w_full, w_empty, w_push, w_store, w_pop, w_pop_any;
    logic          w_pop_last, w_push_fresh;
    logic [BW-1:0] w_pop_bkt, w_push_bkt;
    logic [AW-1:0] w_pop_slot;
    slot_t         w_pop_ent;
    logic [CW-1:0] w_tcnt_d [TENANTS];

    nexus_bucket_ffs #(
        .NB (NB),
        .IW (BW)
    ) u_ffs (
        .i_bitmap (r_bitmap),
        .o_idx    (w_pop_bkt),
        .o_any    (w_pop_any)
    );

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_push     = io_bus.i_push_valid && !w_full;
    assign w_store    = w_push && (r_tcnt[io_bus.i_push_tenant] < QUOTA_CNT);
    assign w_pop      = io_bus.i_pop && !w_empty && w_pop_any;
    assign w_push_bkt = io_bus.i_push_prio[PTW-1 -: BW];
    assign w_pop_slot = r_head[w_pop_bkt];
    assign w_pop_ent  = r_mem[w_pop_slot];
    assign w_pop_last = (r_head[w_pop_bkt] == r_tail[w_pop_bkt]);
    // A push into the bucket whose only entry is popped this cycle must restart the list.
    assign w_push_fresh = !r_bitmap[w_push_bkt] ||
                          (w_pop && w_pop_last && (w_pop_bkt == w_push_bkt));

    always_comb begin
        for (int t = 0; t < TENANTS; t++) begin
            w_tcnt_d[t] = r_tcnt[t];
            if (w_store && (io_bus.i_push_tenant == TW'(t))) w_tcnt_d[t] = w_tcnt_d[t] + CW'(1);
            if (w_pop && (w_pop_ent.tenant == TW'(t)))       w_tcnt_d[t] = w_tcnt_d[t] - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_store) begin
            r_mem[r_free] <= '{prio: io_bus.i_push_prio, tenant: io_bus.i_push_tenant,
                               meta: io_bus.i_push_meta};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_next[i] <= AW'(i + 1);
            for (int b = 0; b < NB; b++) begin
                r_head[b] <= '0;
                r_tail[b] <= '0;
            end
            for (int t = 0; t < TENANTS; t++) r_tcnt[t] <= '0;
            r_bitmap      <= '0;
            r_count       <= '0;
            r_free        <= '0;
            r_pop_valid   <= 1'b0;
            r_pop         <= '0;
            r_drop        <= 1'b0;
            r_drop_tenant <= '0;
        end else begin
            for (int t = 0; t < TENANTS; t++) r_tcnt[t] <= w_tcnt_d[t];
            r_count     <= r_count + CW'(w_store) - CW'(w_pop);
            r_pop_valid <= w_pop;
            r_drop      <= w_push && !w_store;
            if (w_push && !w_store) r_drop_tenant <= io_bus.i_push_tenant;

            // Freed slot becomes the new free head; a concurrent push consumes the old head.
            if (w_pop) begin
                r_pop               <= w_pop_ent;
                r_next[w_pop_slot]  <= w_store ? r_next[r_free] : r_free;
                r_free              <= w_pop_slot;
                r_head[w_pop_bkt]   <= r_next[w_pop_slot];
                if (w_pop_last) r_bitmap[w_pop_bkt] <= 1'b0;
            end else if (w_store) begin
                r_free <= r_next[r_free];
            end

            if (w_store) begin
                if (w_push_fresh) r_head[w_push_bkt] <= r_free;
                else              r_next[r_tail[w_push_bkt]] <= r_free;
                r_tail[w_push_bkt]   <= r_free;
                r_bitmap[w_push_bkt] <= 1'b1;
            end
        end
    end

    assign io_bus.o_push_ready  = !w_full;
    assign io_bus.o_pop_valid   = r_pop_valid;
    assign io_bus.o_pop_prio    = r_pop.prio;
    assign io_bus.o_pop_tenant  = r_pop.tenant;
    assign io_bus.o_pop_meta    = r_pop.meta;
    assign io_bus.o_drop        = r_drop;
    assign io_bus.o_drop_tenant = r_drop_tenant;
    assign io_bus.o_count       = r_count;
    assign io_bus.o_empty       = w_empty;
    assign io_bus.o_full        = w_full;

endmodule

// File: tb/tb_nexus_bucket_pifo.sv
// Bench for nexus_bucket_pifo: a reference model feeds an expected-pop queue; one task per scenario.
module tb_nexus_bucket_pifo;
    import nexus_pifo_pkg::*;

    localparam int DEP = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nexus_bucket_pifo_if #(.PTW(16), .MTW(32), .TNW(2), .ADW(6)) bus_a ();
    nexus_bucket_pifo_if #(.PTW(16), .MTW(32), .TNW(2), .ADW(6)) bus_b ();

    nexus_bucket_pifo #(
        .PTW(16), .MTW(32), .NB(16), .DEPTH(64), .TENANTS(4), .QUOTA(64)
    ) dut_a (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus_a)
    );

    nexus_bucket_pifo #(
        .PTW(16), .MTW(32), .NB(16), .DEPTH(64), .TENANTS(4), .QUOTA(2)
    ) dut_b (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus_b)
    );

    int     errors = 0;
    int     checks = 0;
    entry_t mdl[$];
    entry_t exp_q[$];

    // One clock on dut_a with the model advanced from pre-edge state.
    task automatic cycle_a(input bit pv, input logic [15:0] prio, input logic [1:0] ten,
                           input logic [31:0] meta, input bit pop);
        entry_t e;
        bit     pop_ok;
        bit     acc;
        int     best;
        pop_ok = pop && (mdl.size() > 0);
        acc    = pv && (mdl.size() < DEP);
        if (pop_ok) begin
            best = 0;
            for (int i = 1; i < mdl.size(); i++)
                if (mdl[i].prio[15:12] < mdl[best].prio[15:12]) best = i;
            exp_q.push_back(mdl[best]);
            mdl.delete(best);
        end
        if (acc) begin
            e.prio = prio; e.tenant = ten; e.meta = meta;
            mdl.push_back(e);
        end
        bus_a.i_push_valid  = pv;
        bus_a.i_push_prio   = prio;
        bus_a.i_push_tenant = ten;
        bus_a.i_push_meta   = meta;
        bus_a.i_pop         = pop;
        @(posedge clk); #1;
        bus_a.i_push_valid = 1'b0;
        bus_a.i_pop        = 1'b0;
        checks++;
        if (bus_a.o_pop_valid !== pop_ok) begin
            errors++;
            $display("FAIL pop_valid: got %b want %b", bus_a.o_pop_valid, pop_ok);
        end
        if (pop_ok) begin
            e = exp_q.pop_front();
            checks++;
            if ({bus_a.o_pop_prio, bus_a.o_pop_tenant, bus_a.o_pop_meta} !== e) begin
                errors++;
                $display("FAIL pop_entry: got %h/%0d/%h want %h/%0d/%h", bus_a.o_pop_prio,
                         bus_a.o_pop_tenant, bus_a.o_pop_meta, e.prio, e.tenant, e.meta);
            end
        end
        checks++;
        if (bus_a.o_count !== 7'(mdl.size()) || bus_a.o_drop !== 1'b0) begin
            errors++;
            $display("FAIL count: got %0d drop %b want %0d drop 0", bus_a.o_count, bus_a.o_drop,
                     mdl.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus_a.o_count !== 7'd0 || bus_a.o_empty !== 1'b1 || bus_a.o_full !== 1'b0 ||
            bus_a.o_push_ready !== 1'b1 || bus_a.o_pop_valid !== 1'b0 ||
            bus_a.o_pop_prio !== 16'h0 || bus_a.o_pop_meta !== 32'h0 ||
            bus_a.o_drop !== 1'b0 || bus_a.o_drop_tenant !== 2'd0) begin
            errors++;
            $display("FAIL reset_a: got cnt %0d emp %b full %b rdy %b pv %b drop %b want 0 1 0 1 0 0",
                     bus_a.o_count, bus_a.o_empty, bus_a.o_full, bus_a.o_push_ready,
                     bus_a.o_pop_valid, bus_a.o_drop);
        end
        checks++;
        if (bus_b.o_count !== 7'd0 || bus_b.o_empty !== 1'b1 || bus_b.o_push_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_b: got cnt %0d emp %b rdy %b want 0 1 1",
                     bus_b.o_count, bus_b.o_empty, bus_b.o_push_ready);
        end
        rst = 1'b0;
        mdl.delete();
        exp_q.delete();
    endtask

    task automatic test_order();
        logic [15:0] want [3];
        want[0] = 16'h2000; want[1] = 16'h5000; want[2] = 16'hA000;
        cycle_a(1, 16'h5000, 2'd0, 32'h1, 0);
        cycle_a(1, 16'h2000, 2'd0, 32'h2, 0);
        cycle_a(1, 16'hA000, 2'd0, 32'h3, 0);
        for (int i = 0; i < 3; i++) begin
            cycle_a(0, 16'h0, 2'd0, 32'h0, 1);
            checks++;
            if (bus_a.o_pop_prio !== want[i]) begin
                errors++;
                $display("FAIL order_%0d: got %h want %h", i, bus_a.o_pop_prio, want[i]);
            end
        end
        checks++;
        if (bus_a.o_empty !== 1'b1) begin
            errors++;
            $display("FAIL order_empty: got %b want 1", bus_a.o_empty);
        end
    endtask

    task automatic test_fifo();
        logic [15:0] lowp [3];
        for (int i = 0; i < 3; i++) cycle_a(1, 16'h0300, 2'd1, 32'(i + 1), 0);
        for (int i = 0; i < 3; i++) begin
            cycle_a(0, 16'h0, 2'd0, 32'h0, 1);
            checks++;
            if (bus_a.o_pop_meta !== 32'(i + 1)) begin
                errors++;
                $display("FAIL fifo_%0d: got %0d want %0d", i, bus_a.o_pop_meta, i + 1);
            end
        end
        cycle_a(0, 16'h0, 2'd0, 32'h0, 1);
        // Bits below the bucket field are not sorted: these all share bucket 0.
        lowp[0] = 16'h0500; lowp[1] = 16'h0200; lowp[2] = 16'h0A00;
        for (int i = 0; i < 3; i++) cycle_a(1, lowp[i], 2'd0, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle_a(0, 16'h0, 2'd0, 32'h0, 1);
            checks++;
            if (bus_a.o_pop_prio !== lowp[i]) begin
                errors++;
                $display("FAIL approx_%0d: got %h want %h", i, bus_a.o_pop_prio, lowp[i]);
            end
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEP; i++) cycle_a(1, 16'($urandom), 2'(i % 4), 32'(i), 0);
        checks++;
        if (bus_a.o_full !== 1'b1 || bus_a.o_push_ready !== 1'b0) begin
            errors++;
            $display("FAIL full: got full %b ready %b want 1 0", bus_a.o_full, bus_a.o_push_ready);
        end
        cycle_a(1, 16'h1234, 2'd0, 32'hDEAD, 1);
        checks++;
        if (bus_a.o_count !== 7'd63 || bus_a.o_push_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_pushpop: got cnt %0d ready %b want 63 1", bus_a.o_count,
                     bus_a.o_push_ready);
        end
        for (int i = 0; i < DEP - 1; i++) cycle_a(0, 16'h0, 2'd0, 32'h0, 1);
        checks++;
        if (bus_a.o_empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: got %b want 1", bus_a.o_empty);
        end
    endtask

    task automatic test_same_bucket();
        cycle_a(1, 16'h4001, 2'd2, 32'hA, 0);
        cycle_a(1, 16'h4002, 2'd2, 32'hB, 1);
        checks++;
        if (bus_a.o_pop_meta !== 32'hA || bus_a.o_count !== 7'd1) begin
            errors++;
            $display("FAIL same_bkt_first: got meta %h cnt %0d want a 1", bus_a.o_pop_meta,
                     bus_a.o_count);
        end
        cycle_a(0, 16'h0, 2'd0, 32'h0, 1);
        checks++;
        if (bus_a.o_pop_meta !== 32'hB || bus_a.o_pop_prio !== 16'h4002) begin
            errors++;
            $display("FAIL same_bkt_second: got %h/%h want 4002/b", bus_a.o_pop_prio,
                     bus_a.o_pop_meta);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++)
            cycle_a(($urandom_range(0, 9) < 6), 16'($urandom), 2'($urandom), $urandom,
                    ($urandom_range(0, 1) == 1));
        for (int i = 0; i < DEP && mdl.size() > 0; i++) cycle_a(0, 16'h0, 2'd0, 32'h0, 1);
    endtask

    task automatic test_quota();
        logic [1:0]  ten  [4];
        logic [15:0] pr   [4];
        logic        dexp [4];
        logic [6:0]  cexp [4];
        ten[0] = 2'd1; ten[1] = 2'd1; ten[2] = 2'd1; ten[3] = 2'd2;
        pr[0] = 16'h1000; pr[1] = 16'h1000; pr[2] = 16'h1000; pr[3] = 16'h2000;
        dexp[0] = 0; dexp[1] = 0; dexp[2] = 1; dexp[3] = 0;
        cexp[0] = 7'd1; cexp[1] = 7'd2; cexp[2] = 7'd2; cexp[3] = 7'd3;
        for (int i = 0; i < 4; i++) begin
            bus_b.i_push_valid  = 1'b1;
            bus_b.i_push_tenant = ten[i];
            bus_b.i_push_prio   = pr[i];
            bus_b.i_push_meta   = 32'(i + 1);
            @(posedge clk); #1;
            checks++;
            if (bus_b.o_drop !== dexp[i] || bus_b.o_count !== cexp[i] ||
                (dexp[i] && bus_b.o_drop_tenant !== 2'd1)) begin
                errors++;
                $display("FAIL quota_%0d: got drop %b/%0d cnt %0d want %b/1 %0d", i, bus_b.o_drop,
                         bus_b.o_drop_tenant, bus_b.o_count, dexp[i], cexp[i]);
            end
        end
        // Same-cycle pop of tenant 1 must not free quota for its push.
        bus_b.i_push_tenant = 2'd1;
        bus_b.i_push_prio   = 16'h1000;
        bus_b.i_push_meta   = 32'h9;
        bus_b.i_pop         = 1'b1;
        @(posedge clk); #1;
        bus_b.i_push_valid = 1'b0;
        checks++;
        if (bus_b.o_drop !== 1'b1 || bus_b.o_drop_tenant !== 2'd1 || bus_b.o_count !== 7'd2 ||
            bus_b.o_pop_valid !== 1'b1 || bus_b.o_pop_meta !== 32'h1) begin
            errors++;
            $display("FAIL quota_pushpop: got drop %b cnt %0d pv %b meta %h want 1 2 1 1",
                     bus_b.o_drop, bus_b.o_count, bus_b.o_pop_valid, bus_b.o_pop_meta);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus_b.o_pop_meta !== ((i == 0) ? 32'h2 : 32'h4) || bus_b.o_drop !== 1'b0) begin
                errors++;
                $display("FAIL quota_drain_%0d: got meta %h drop %b want %h 0", i,
                         bus_b.o_pop_meta, bus_b.o_drop, (i == 0) ? 32'h2 : 32'h4);
            end
        end
        bus_b.i_pop = 1'b0;
        checks++;
        if (bus_b.o_empty !== 1'b1) begin
            errors++;
            $display("FAIL quota_empty: got %b want 1", bus_b.o_empty);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) cycle_a(1, 16'(i * 16'h1100), 2'(i), 32'(i), (i == 5));
        bus_a.i_push_valid = 1'b1;
        bus_a.i_pop        = 1'b1;
        rst                = 1'b1;
        @(posedge clk); #1;
        rst                = 1'b0;
        bus_a.i_push_valid = 1'b0;
        bus_a.i_pop        = 1'b0;
        mdl.delete();
        exp_q.delete();
        checks++;
        if (bus_a.o_count !== 7'd0 || bus_a.o_empty !== 1'b1 || bus_a.o_full !== 1'b0 ||
            bus_a.o_push_ready !== 1'b1 || bus_a.o_pop_valid !== 1'b0 ||
            bus_a.o_pop_prio !== 16'h0 || bus_a.o_drop !== 1'b0 ||
            bus_a.o_drop_tenant !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid: got cnt %0d emp %b rdy %b pv %b prio %h want 0 1 1 0 0",
                     bus_a.o_count, bus_a.o_empty, bus_a.o_push_ready, bus_a.o_pop_valid,
                     bus_a.o_pop_prio);
        end
        cycle_a(0, 16'h0, 2'd0, 32'h0, 1);
        cycle_a(1, 16'h7777, 2'd3, 32'h55, 0);
        cycle_a(1, 16'h3333, 2'd0, 32'h66, 0);
        cycle_a(0, 16'h0, 2'd0, 32'h0, 1);
        cycle_a(0, 16'h0, 2'd0, 32'h0, 1);
    endtask

    initial begin
        bus_a.i_push_valid = 1'b0; bus_a.i_push_prio = '0; bus_a.i_push_tenant = '0;
        bus_a.i_push_meta  = '0;   bus_a.i_pop = 1'b0;
        bus_b.i_push_valid = 1'b0; bus_b.i_push_prio = '0; bus_b.i_push_tenant = '0;
        bus_b.i_push_meta  = '0;   bus_b.i_pop = 1'b0;
        test_reset();
        test_order();
        test_fifo();
        test_full();
        test_same_bucket();
        test_back_to_back();
        test_quota();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
